din_sync_debounce: RTL and testbench

//   Receive end for asynchronous single-bit control inputs: synchronises WIDTH independent

---
 rtl/din_sync_pkg.sv | 12 +
 rtl/debounce_bit.sv | 112 +++++++++++
 rtl/din_sync_debounce.sv | 70 +++++++
 tb/tb_din_sync_debounce.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/din_sync_pkg.sv
// Shared types and constants for the din_sync_debounce input receiver.
package din_sync_pkg;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_CHANGING = 1'b1
    } deb_state_e;

    localparam int unsigned GLITCH_CNT_W = 16;
    localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = '1;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: synchroniser chain, debounce FSM and hold counter.
// With SYNC_GLITCH_CNT_EN defined, an abort_c strobe flags a rejected transition.
module debounce_bit
    import din_sync_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic        RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic en,
    output logic q,
    output logic rise,
    output logic fall,
    output logic pulse_nxt_c
`ifdef SYNC_GLITCH_CNT_EN
    ,
    output logic abort_c
`endif
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_bit: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
        $error("debounce_bit: DEBOUNCE_CYCLES must be >= 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    deb_state_e             state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   q_nxt, rise_nxt, fall_nxt, abort_nxt;

    // Plain flop chain; nothing else looks at din.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_STABLE;
            cnt   <= '0;
            q     <= RESET_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            q     <= q_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    // A new value must survive DEBOUNCE_CYCLES consecutive cycles before q follows.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        q_nxt     = q;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        abort_nxt = 1'b0;
        if (!en) begin
            state_nxt = ST_STABLE;
        end else begin
            case (state)
                ST_STABLE: begin
                    if (s != q) begin
                        state_nxt = ST_CHANGING;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
                ST_CHANGING: begin
                    if (s == q) begin
                        state_nxt = ST_STABLE;
                        abort_nxt = 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = ST_STABLE;
                        q_nxt     = s;
                        rise_nxt  = s;
                        fall_nxt  = ~s;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: state_nxt = ST_STABLE;
            endcase
        end
    end

    assign pulse_nxt_c = rise_nxt | fall_nxt;

`ifdef SYNC_GLITCH_CNT_EN
    assign abort_c = abort_nxt;
`else
    logic unused_abort;
    assign unused_abort = abort_nxt;
`endif

endmodule

// File: rtl/din_sync_debounce.sv
// Synchronise and debounce WIDTH async control inputs, with level and edge pulses.
// Optional SYNC_GLITCH_CNT_EN adds a saturating count of cycles with rejected transitions.
module din_sync_debounce
    import din_sync_pkg::*;
#(
    parameter int unsigned      WIDTH           = 1,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
`ifdef SYNC_GLITCH_CNT_EN
    ,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

    logic [WIDTH-1:0] pulse_nxt;
`ifdef SYNC_GLITCH_CNT_EN
    logic [WIDTH-1:0] abort;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VAL      (RESET_VAL[i])
        ) u_bit (
            .clk        (clk),
            .rst        (rst),
            .din        (din[i]),
            .en         (en),
            .q          (q[i]),
            .rise       (rise[i]),
            .fall       (fall[i]),
            .pulse_nxt_c(pulse_nxt[i])
`ifdef SYNC_GLITCH_CNT_EN
            ,
            .abort_c    (abort[i])
`endif
        );
    end

    // Registered from the per-bit next-pulse terms so it lines up with rise/fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            changed <= 1'b0;
        end else begin
            changed <= |pulse_nxt;
        end
    end

`ifdef SYNC_GLITCH_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_cnt <= '0;
        end else if (|abort && (glitch_cnt != GLITCH_CNT_MAX)) begin
            glitch_cnt <= glitch_cnt + GLITCH_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_din_sync_debounce.sv
// Directed bench for din_sync_debounce (WIDTH=2, 2 sync stages, 4 debounce cycles).
module tb_din_sync_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] din;
    logic       en;
    logic [1:0] q, rise, fall;
    logic       changed;
`ifdef SYNC_GLITCH_CNT_EN
    logic [15:0] glitch_cnt;
`endif

    int total = 0;
    int bad   = 0;

    din_sync_debounce #(
        .WIDTH          (2),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .RESET_VAL      (2'b00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .en        (en),
        .q         (q),
        .rise      (rise),
        .fall      (fall),
        .changed   (changed)
`ifdef SYNC_GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_outs(input string tag, input logic [1:0] eq, input logic [1:0] er,
                               input logic [1:0] ef);
        check_val({tag, "_q"}, 32'(q), 32'(eq));
        check_val({tag, "_rise"}, 32'(rise), 32'(er));
        check_val({tag, "_fall"}, 32'(fall), 32'(ef));
        check_val({tag, "_chg"}, 32'(changed), 32'(|(er | ef)));
    endtask

    task automatic check_glitch(input string tag, input int exp);
`ifdef SYNC_GLITCH_CNT_EN
        check_val(tag, 32'(glitch_cnt), 32'(exp));
`else
        if (exp < 0) $display("unused %s", tag);
`endif
    endtask

    // Leaves the bench 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Change din at an arbitrary point inside the current cycle.
    task automatic drive(input logic [1:0] v);
        #($urandom_range(0, 6));
        din = v;
    endtask

    // n-1 edges holding old_q with no pulses, then new_q with pulses r/f for one cycle only.
    task automatic settle(input string tag, input int n, input logic [1:0] old_q,
                          input logic [1:0] new_q, input logic [1:0] r, input logic [1:0] f);
        for (int i = 1; i < n; i++) begin
            step(1);
            expect_outs({tag, "_hold"}, old_q, 2'b00, 2'b00);
        end
        step(1);
        expect_outs({tag, "_edge"}, new_q, r, f);
        step(1);
        expect_outs({tag, "_after"}, new_q, 2'b00, 2'b00);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        din = 2'b11;

        // 1: reset holds q at 00 even with din high; release gives rise=11 after 6 edges
        step(2);
        expect_outs("t1_rst", 2'b00, 2'b00, 2'b00);
        check_glitch("t1_glitch", 0);
        rst = 1'b0;
        settle("t1", 6, 2'b00, 2'b11, 2'b11, 2'b00);
        drive(2'b00);
        settle("t1b", 6, 2'b11, 2'b00, 2'b00, 2'b11);

        // 2: clean rise and fall on bit 0
        drive(2'b01);
        settle("t2", 6, 2'b00, 2'b01, 2'b01, 2'b00);
        drive(2'b00);
        settle("t2b", 6, 2'b01, 2'b00, 2'b00, 2'b01);

        // 3: two-cycle pulse on bit 0 is rejected
        drive(2'b01);
        step(2);
        drive(2'b00);
        settle("t3", 6, 2'b00, 2'b00, 2'b00, 2'b00);
        check_glitch("t3_glitch", 1);

        // 4: simultaneous rise on bit 0 and fall on bit 1
        drive(2'b10);
        settle("t4a", 6, 2'b00, 2'b10, 2'b10, 2'b00);
        drive(2'b01);
        settle("t4", 6, 2'b10, 2'b01, 2'b01, 2'b10);
        drive(2'b00);
        settle("t4b", 6, 2'b01, 2'b00, 2'b00, 2'b01);

        // 5: en=0 freezes q; re-enable starts a full window
        en = 1'b0;
        drive(2'b01);
        step(1);
        expect_outs("t5_frz0", 2'b00, 2'b00, 2'b00);
        drive(2'b10);
        step(3);
        expect_outs("t5_frz1", 2'b00, 2'b00, 2'b00);
        drive(2'b11);
        for (int i = 0; i < 8; i++) begin
            step(1);
            expect_outs("t5_frz2", 2'b00, 2'b00, 2'b00);
        end
        check_glitch("t5_glitch_off", 1);
        en = 1'b1;
        settle("t5", 4, 2'b00, 2'b11, 2'b11, 2'b00);
        check_glitch("t5_glitch_on", 1);

        // 6: reset while bit 0 is mid-debounce (cnt=2)
        drive(2'b10);
        settle("t6a", 6, 2'b11, 2'b10, 2'b00, 2'b01);
        drive(2'b11);
        step(4);
        expect_outs("t6_pre", 2'b10, 2'b00, 2'b00);
        rst = 1'b1;
        #2;
        expect_outs("t6_rst", 2'b00, 2'b00, 2'b00);
        check_glitch("t6_glitch_rst", 0);
        step(2);
        drive(2'b00);
        rst = 1'b0;
        settle("t6_low", 8, 2'b00, 2'b00, 2'b00, 2'b00);
        rst = 1'b1;
        drive(2'b01);
        step(2);
        expect_outs("t6_rst2", 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        settle("t6_high", 6, 2'b00, 2'b01, 2'b01, 2'b00);
        check_glitch("t6_glitch_end", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
